// File: rtl/echo_canceller.sv
// Single-tap feedback echo remover: x[n] = y[n] - (y[n-DELAY] >>> ATT_SHIFT), one sample per strobe.
// Define ECHO_CANCEL_SAT_EN to saturate the result and add sat_flag; otherwise the result wraps.
module echo_canceller #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DELAY     = 2048,
  parameter int unsigned ATT_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              enable,
  input  logic [DATA_W-1:0] signal,
  output logic              out_valid,
  output logic [DATA_W-1:0] signal_out
`ifdef ECHO_CANCEL_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int unsigned PtrW  = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int unsigned FillW = $clog2(DELAY + 1);
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(DELAY - 1);
  localparam logic [FillW-1:0] FillMax = FillW'(DELAY);

  logic [DATA_W-1:0]        r_mem [DELAY];
  logic [PtrW-1:0]          r_wr_ptr;
  logic [FillW-1:0]         r_fill_cnt;
  logic signed [DATA_W-1:0] w_delayed;
  logic signed [DATA_W-1:0] w_tap;
  logic [DATA_W-1:0]        w_result;

  // Stale RAM contents stay invisible until a full delay line has been written.
  assign w_delayed = (r_fill_cnt == FillMax) ? $signed(r_mem[r_wr_ptr]) : '0;
  assign w_tap     = w_delayed >>> ATT_SHIFT;

`ifdef ECHO_CANCEL_SAT_EN
  logic signed [DATA_W:0] w_diff;
  logic                   w_clip;

  assign w_diff = $signed({signal[DATA_W-1], signal}) - $signed({w_tap[DATA_W-1], w_tap});
  // Overflow iff the sign bit and the extension bit disagree.
  assign w_clip = w_diff[DATA_W] ^ w_diff[DATA_W-1];
  assign w_result = !w_clip      ? w_diff[DATA_W-1:0] :
                    w_diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                     {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign w_result = signal - w_tap;
`endif

  // Read-before-write at r_wr_ptr gives the sample from exactly DELAY strobes ago.
  always_ff @(posedge clk) begin
    if (in_valid && !reset) begin
      r_mem[r_wr_ptr] <= signal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      out_valid  <= 1'b0;
      signal_out <= '0;
`ifdef ECHO_CANCEL_SAT_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
`ifdef ECHO_CANCEL_SAT_EN
      sat_flag  <= in_valid && enable && w_clip;
`endif
      if (in_valid) begin
        r_wr_ptr   <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + PtrW'(1);
        signal_out <= enable ? w_result : signal;
        if (r_fill_cnt != FillMax) begin
          r_fill_cnt <= r_fill_cnt + FillW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_echo_canceller.sv
// Randomized self-checking bench for echo_canceller (DELAY=4, ATT_SHIFT=2) with a queue-based model.
// Honours ECHO_CANCEL_SAT_EN to match the saturating build.
`timescale 1ns/1ps
module tb_echo_canceller;

  localparam int D = 4;
`ifdef ECHO_CANCEL_SAT_EN
  localparam bit SatOn = 1'b1;
`else
  localparam bit SatOn = 1'b0;
`endif

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        in_valid = 1'b0;
  logic        enable   = 1'b1;
  logic [15:0] signal   = '0;
  logic        out_valid;
  logic [15:0] signal_out;
`ifdef ECHO_CANCEL_SAT_EN
  logic        sat_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  echo_canceller #(
    .DATA_W   (16),
    .DELAY    (D),
    .ATT_SHIFT(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .enable    (enable),
    .signal    (signal),
    .out_valid (out_valid),
`ifdef ECHO_CANCEL_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .signal_out(signal_out)
  );

  task automatic chk(input string name, input logic signed [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Division by 4 rounding toward minus infinity.
  function automatic int floor_q(input int v);
    return (v >= 0) ? v / 4 : -((-v + 3) / 4);
  endfunction

  function automatic int wrap16(input int v);
    int m;
    m = ((v % 65536) + 65536) % 65536;
    return (m >= 32768) ? m - 65536 : m;
  endfunction

  function automatic int model(input int y, input int delayed, input bit en, output bit clip);
    int diff;
    diff = y - floor_q(delayed);
    clip = 1'b0;
    if (!en) return y;
    if (SatOn && diff > 32767) begin
      clip = 1'b1;
      return 32767;
    end
    if (SatOn && diff < -32768) begin
      clip = 1'b1;
      return -32768;
    end
    return wrap16(diff);
  endfunction

  // Per-cycle compare process: model advances at posedge, outputs checked at negedge.
  initial begin
    int  hist[$];
    int  exp_out;
    int  del;
    bit  exp_valid;
    bit  exp_sat;
    bit  c;
    exp_out   = 0;
    exp_valid = 1'b0;
    exp_sat   = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        hist.delete();
        exp_valid = 1'b0;
        exp_out   = 0;
        exp_sat   = 1'b0;
      end else begin
        exp_valid = in_valid;
        exp_sat   = 1'b0;
        if (in_valid) begin
          del     = (hist.size() == D) ? hist[0] : 0;
          exp_out = model(int'($signed(signal)), del, enable, c);
          exp_sat = c;
          hist.push_back(int'($signed(signal)));
          if (hist.size() > D) void'(hist.pop_front());
        end
      end
      @(negedge clk);
      chk("out_valid", out_valid, int'(exp_valid));
      chk("signal_out", $signed(signal_out), exp_out);
`ifdef ECHO_CANCEL_SAT_EN
      chk("sat_flag", sat_flag, int'(exp_sat));
`endif
    end
  end

  // Caller sits at a negedge; returns at a negedge with the result visible.
  task automatic send(input bit en, input int s, input int gap, output int got);
    in_valid = 1'b1;
    enable   = en;
    signal   = 16'(s);
    @(negedge clk);
    in_valid = 1'b0;
    signal   = 16'($urandom);
    got      = int'($signed(signal_out));
    repeat (gap) @(negedge clk);
  endtask

  // Strobe coincident with reset must be ignored.
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    signal   = 16'd12345;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("reset out_valid", out_valid, 0);
    chk("reset signal_out", $signed(signal_out), 0);
  endtask

  initial begin
    int got;
    int x;
    int y;
    int ys[$];
    int t1_in[8]  = '{1000, 0, 0, 0, 0, 0, 0, 0};
    int t1_exp[8] = '{1000, 0, 0, 0, -250, 0, 0, 0};
    logic signed [15:0] r16;

    repeat (2) @(negedge clk);
    do_reset();

    // Impulse: echo term appears DELAY samples later.
    foreach (t1_in[i]) begin
      send(1'b1, t1_in[i], 0, got);
      chk("impulse", got, t1_exp[i]);
    end

    // Sign-extending shift: -3 >>> 2 = -1.
    do_reset();
    send(1'b1, -3, 0, got);
    repeat (3) send(1'b1, 0, 0, got);
    send(1'b1, 0, 0, got);
    chk("neg shift", got, 1);

    // Overflow corner.
    do_reset();
    send(1'b1, 32767, 0, got);
    repeat (3) send(1'b1, 0, 1, got);
    send(1'b1, -32768, 0, got);
    chk("overflow", got, SatOn ? -32768 : 24577);
`ifdef ECHO_CANCEL_SAT_EN
    chk("overflow sat_flag", sat_flag, 1);
`endif

    // Mid-stream reset restarts warm-up; enable=0 passes through but keeps the line filling.
    do_reset();
    for (int i = 1; i <= 6; i++) send(1'b1, i * 1111, 0, got);
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, i * 100, 0, got);
      chk("warmup restart", got, i * 100);
    end
    repeat (3) begin
      send(1'b0, 1000, 0, got);
      chk("bypass", got, 1000);
    end
    send(1'b1, 0, 0, got);
    chk("re-enable", got, -100);

`ifndef ECHO_CANCEL_SAT_EN
    // Generator followed by canceller must be identity, warm-up included.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      r16 = 16'($urandom);
      x   = int'(r16);
      y   = wrap16(x + ((n >= D) ? floor_q(ys[n-D]) : 0));
      ys.push_back(y);
      send(1'b1, y, $urandom_range(0, 2), got);
      chk("identity", got, x);
    end
`endif

    // Random gaps, enables, extremes and occasional resets; per-cycle process checks all.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 40) == 0) do_reset();
      r16 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) r16 = ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000;
      send($urandom_range(0, 5) != 0, int'(r16), $urandom_range(0, 5), got);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
